// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: takes a parallel pattern over valid/ready and shifts it out MSB first on A.
// Optional continuous-loop mode with a stop request is enabled by defining SEQ_GEN_LOOP_EN.
module seq_pattern_gen #(
    parameter int  WIDTH = 8,
    parameter int  GAP   = 0,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
`ifdef SEQ_GEN_LOOP_EN
    input  logic             stop,
`endif
    output logic             A,
    output logic             A_valid,
    output logic             busy,
    output logic             done
);

    localparam int               GAP_W    = $clog2(GAP + 2);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shift, shift_d;
    logic [WIDTH-1:0] pat, pat_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic [LEN_W-1:0] plen, plen_d;
    logic [GAP_W-1:0] gap_cnt, gap_d;
    logic             a_d, a_valid_d, busy_d, done_d;
    logic             load_new, load_rep, restart;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len, len_clamped;

    // A length of zero or beyond WIDTH means a full-width frame.
    assign len_clamped = (in_len == '0 || in_len > FULL_LEN) ? FULL_LEN : in_len;
    assign in_ready    = (state == S_IDLE) && !rst;

`ifdef SEQ_GEN_LOOP_EN
    logic stop_req, stop_req_d;

    assign restart = !(stop_req || stop);

    always_comb begin
        stop_req_d = stop_req || stop;
        if (state == S_IDLE) begin
            stop_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_req <= 1'b0;
        end else begin
            stop_req <= stop_req_d;
        end
    end
`else
    assign restart = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        pat_d     = pat;
        cnt_d     = cnt;
        plen_d    = plen;
        gap_d     = gap_cnt;
        a_d       = 1'b0;
        a_valid_d = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        load_new  = 1'b0;
        load_rep  = 1'b0;
        load_data = pat;
        load_len  = plen;

        unique case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (in_valid) begin
                    load_new = 1'b1;
                end
            end
            // cnt holds the number of bits still to go after the one currently on A.
            S_SEND: begin
                if (cnt == '0) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        busy_d  = 1'b1;
                        gap_d   = GAP_W'(GAP - 1);
                    end else if (restart) begin
                        load_rep = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    a_d       = shift[WIDTH-1];
                    a_valid_d = 1'b1;
                    shift_d   = {shift[WIDTH-2:0], 1'b0};
                    cnt_d     = cnt - LEN_W'(1);
                    done_d    = (cnt == LEN_W'(1));
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (restart) begin
                        load_rep = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (load_new) begin
            load_data = in_data;
            load_len  = len_clamped;
            pat_d     = in_data;
            plen_d    = len_clamped;
        end

        // Loading puts the first bit on A immediately, so the frame starts the next cycle.
        if (load_new || load_rep) begin
            state_d   = S_SEND;
            a_d       = load_data[WIDTH-1];
            a_valid_d = 1'b1;
            busy_d    = 1'b1;
            shift_d   = {load_data[WIDTH-2:0], 1'b0};
            cnt_d     = load_len - LEN_W'(1);
            done_d    = (load_len == LEN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shift   <= '0;
            pat     <= '0;
            cnt     <= '0;
            plen    <= '0;
            gap_cnt <= '0;
            A       <= 1'b0;
            A_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            pat     <= pat_d;
            cnt     <= cnt_d;
            plen    <= plen_d;
            gap_cnt <= gap_d;
            A       <= a_d;
            A_valid <= a_valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: a GAP=0 instance and a GAP=2 instance share clock and reset.
// Loop-mode sequences run only when SEQ_GEN_LOOP_EN is defined.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid2;
    logic [7:0] in_data, in_data2;
    logic [3:0] in_len, in_len2;
    logic       in_ready, in_ready2;
    logic       a_bit, a_bit2;
    logic       a_valid, a_valid2;
    logic       busy, busy2;
    logic       done, done2;
`ifdef SEQ_GEN_LOOP_EN
    logic       stop, stop2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] len;
        int         n;
        logic [7:0] bits;
    } vec_t;

    vec_t       vecs[6];
    logic [4:0] exp_seq[16];

    always #5 clk = ~clk;

    seq_pattern_gen #(.WIDTH(8), .GAP(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
`ifdef SEQ_GEN_LOOP_EN
        .stop     (stop),
`endif
        .A        (a_bit),
        .A_valid  (a_valid),
        .busy     (busy),
        .done     (done)
    );

    seq_pattern_gen #(.WIDTH(8), .GAP(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .in_data  (in_data2),
        .in_len   (in_len2),
`ifdef SEQ_GEN_LOOP_EN
        .stop     (stop2),
`endif
        .A        (a_bit2),
        .A_valid  (a_valid2),
        .busy     (busy2),
        .done     (done2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and drive the selected instance; the other one sees no offer.
    task automatic applyStimulus(input logic sel, input logic v, input logic [7:0] d, input logic [3:0] l);
        @(negedge clk);
        if (sel) begin
            in_valid  = 1'b0;
            in_valid2 = v;
            in_data2  = d;
            in_len2   = l;
        end else begin
            in_valid2 = 1'b0;
            in_valid  = v;
            in_data   = d;
            in_len    = l;
        end
    endtask

    task automatic run_vec(input vec_t v);
        applyStimulus(0, 1'b1, v.data, v.len);
        checkOutput({v.name, " ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < v.n; i++) begin
            applyStimulus(0, 1'b0, 8'h3C ^ 8'(i), 4'd5);
            checkOutput($sformatf("%s valid%0d", v.name, i), 32'(a_valid), 32'd1);
            checkOutput($sformatf("%s bit%0d", v.name, i), 32'(a_bit), 32'(v.bits[7-i]));
            checkOutput($sformatf("%s done%0d", v.name, i), 32'(done), 32'(i == v.n - 1));
            checkOutput($sformatf("%s busy%0d", v.name, i), 32'(busy), 32'd1);
            checkOutput($sformatf("%s notready%0d", v.name, i), 32'(in_ready), 32'd0);
        end
        applyStimulus(0, 1'b0, 8'h00, 4'd0);
        checkOutput({v.name, " end valid"}, 32'(a_valid), 32'd0);
        checkOutput({v.name, " end A"}, 32'(a_bit), 32'd0);
        checkOutput({v.name, " end done"}, 32'(done), 32'd0);
        checkOutput({v.name, " end busy"}, 32'(busy), 32'd0);
        checkOutput({v.name, " end ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"b2_len8",  8'b1011_0010, 4'd8,  8, 8'b1011_0010};
        vecs[1] = '{"c0_len3",  8'hC0,        4'd3,  3, 8'hC0};
        vecs[2] = '{"ff_len0",  8'hFF,        4'd0,  8, 8'hFF};
        vecs[3] = '{"5a_len9",  8'h5A,        4'd9,  8, 8'h5A};
        vecs[4] = '{"7f_len1",  8'h7F,        4'd1,  1, 8'h00};
        vecs[5] = '{"e1_len15", 8'hE1,        4'd15, 8, 8'hE1};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB2;
        in_len    = 4'd8;
        in_valid2 = 1'b0;
        in_data2  = 8'h00;
        in_len2   = 4'd0;
`ifdef SEQ_GEN_LOOP_EN
        stop      = 1'b1;
        stop2     = 1'b1;
`endif

        // Reset held for three cycles with an offer pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 8'hB2, 4'd8);
            checkOutput($sformatf("rst%0d outs", i), {28'd0, a_bit, a_valid, busy, done}, 32'd0);
            checkOutput($sformatf("rst%0d ready", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("rst%0d ready2", i), 32'(in_ready2), 32'd0);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("release ready", 32'(in_ready), 32'd1);
        checkOutput("release ready2", 32'(in_ready2), 32'd1);
        checkOutput("release outs", {28'd0, a_bit, a_valid, busy, done}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Offer held through a frame: stream unchanged, new pattern taken on the first idle cycle.
        applyStimulus(0, 1'b1, 8'hB2, 4'd8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b1, 8'h0F, 4'd8);
            checkOutput($sformatf("hold ready%0d", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("hold bit%0d", i), {30'd0, a_valid, a_bit}, {31'd1, vecs[0].bits[7-i]});
            checkOutput($sformatf("hold done%0d", i), 32'(done), 32'(i == 7));
        end
        applyStimulus(0, 1'b1, 8'h0F, 4'd8);
        checkOutput("hold idle ready", 32'(in_ready), 32'd1);
        checkOutput("hold idle valid", 32'(a_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, 8'hAA, 4'd3);
            checkOutput($sformatf("second bit%0d", i), {30'd0, a_valid, a_bit}, {31'd1, 1'(i >= 4)});
            checkOutput($sformatf("second done%0d", i), 32'(done), 32'(i == 7));
        end
        applyStimulus(0, 1'b0, 8'h00, 4'd0);
        checkOutput("second end valid", 32'(a_valid), 32'd0);

        // Reset after four bits of 8'hAA drops the frame without a done pulse.
        applyStimulus(0, 1'b1, 8'hAA, 4'd8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, 8'h00, 4'd0);
            checkOutput($sformatf("aa bit%0d", i), {30'd0, a_valid, a_bit}, {31'd1, 1'(i % 2 == 0)});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst outs", {28'd0, a_bit, a_valid, busy, done}, 32'd0);
        checkOutput("midrst ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1'b0, 8'h00, 4'd0);
            checkOutput($sformatf("postrst%0d outs", i), {28'd0, a_bit, a_valid, busy, done}, 32'd0);
            checkOutput($sformatf("postrst%0d ready", i), 32'(in_ready), 32'd1);
        end
        run_vec('{"3c_len6", 8'h3C, 4'd6, 6, 8'h3C});

        // GAP=2 instance, second frame offered early; expected {A_valid, A, busy, done, in_ready}.
        exp_seq[0:9] = '{5'b11100, 5'b11110, 5'b00100, 5'b00100, 5'b00001,
                         5'b10100, 5'b11110, 5'b00100, 5'b00100, 5'b00001};
        applyStimulus(1, 1'b1, 8'hC0, 4'd2);
        checkOutput("gap ready", 32'(in_ready2), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1'(i < 5), 8'h40, 4'd2);
            checkOutput($sformatf("gap cyc%0d", i), {27'd0, a_valid2, a_bit2, busy2, done2, in_ready2},
                        {27'd0, exp_seq[i]});
        end

`ifdef SEQ_GEN_LOOP_EN
        // Loop mode, back-to-back: stop during the second frame ends after that frame.
        exp_seq[0:9] = '{5'b11100, 5'b10100, 5'b11100, 5'b10110, 5'b11100,
                         5'b10100, 5'b11100, 5'b10110, 5'b00001, 5'b00001};
        applyStimulus(0, 1'b1, 8'hA5, 4'd4);
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b0, 8'h00, 4'd0);
            stop = (i == 5);
            checkOutput($sformatf("loop cyc%0d", i), {27'd0, a_valid, a_bit, busy, done, in_ready},
                        {27'd0, exp_seq[i]});
        end
        stop = 1'b1;

        // Loop mode with GAP=2: exactly two empty cycles between frames, gap kept after the last one.
        exp_seq[0:12] = '{5'b11100, 5'b10100, 5'b11100, 5'b10110, 5'b00100, 5'b00100,
                          5'b11100, 5'b10100, 5'b11100, 5'b10110, 5'b00100, 5'b00100, 5'b00001};
        applyStimulus(1, 1'b1, 8'hA5, 4'd4);
        stop2 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1, 1'b0, 8'h00, 4'd0);
            stop2 = (i == 7);
            checkOutput($sformatf("loopgap cyc%0d", i), {27'd0, a_valid2, a_bit2, busy2, done2, in_ready2},
                        {27'd0, exp_seq[i]});
        end
        stop2 = 1'b1;
`endif

        applyStimulus(0, 1'b0, 8'h00, 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
